rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 38 +++
 rtl/rf_write_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundles the handshake, write-port and hazard signals of rf_write_arbiter.
//   master : requester / register-file side (drives requests and read addresses)
//   slave  : the arbiter itself
//   Signals:
//     ValidA/ReadyA, RegA[4:0], DataA[63:0] : requester A (ALU writeback)
//     ValidB/ReadyB, RegB[4:0], DataB[63:0] : requester B (load writeback)
//     RW[4:0], BusW[63:0], RegWr            : registered register-file write port
//     RA[4:0], RB[4:0], HazA, HazB          : read addresses and pending-write hazards
//     Busy                                  : queued work or write in flight
interface rf_write_arbiter_if;
   logic        ValidA;
   logic        ReadyA;
   logic [4:0]  RegA;
   logic [63:0] DataA;
   logic        ValidB;
   logic        ReadyB;
   logic [4:0]  RegB;
   logic [63:0] DataB;
   logic [4:0]  RW;
   logic [63:0] BusW;
   logic        RegWr;
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic        HazA;
   logic        HazB;
   logic        Busy;

   modport master (
      output ValidA, RegA, DataA, ValidB, RegB, DataB, RA, RB,
      input  ReadyA, ReadyB, RW, BusW, RegWr, HazA, HazB, Busy
   );

   modport slave (
      input  ValidA, RegA, DataA, ValidB, RegB, DataB, RA, RB,
      output ReadyA, ReadyB, RW, BusW, RegWr, HazA, HazB, Busy
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Two writeback requesters (A = ALU, B = load) each feed a DEPTH-entry FIFO.
//   One head is granted per cycle (round-robin on ties) and loaded into the
//   registered write port. Entries targeting reg 31 use their slot but never
//   assert RegWr. HazA/HazB flag reads that match any pending write.
//   Ports:
//     Clk    : clock, all state changes on posedge
//     ResetL : asynchronous active-low reset
//     bus    : rf_write_arbiter_if.slave (handshakes, write port, hazards, Busy)
module rf_write_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic               Clk,
   input  logic               ResetL,
   rf_write_arbiter_if.slave  bus
);
   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
   localparam logic [4:0]  REG_NULL = 5'd31;

   // Index 0 = requester A, index 1 = requester B
   logic [4:0]    q_reg  [2][DEPTH];
   logic [63:0]   q_data [2][DEPTH];
   logic [AW-1:0] wr_ptr [2];
   logic [AW-1:0] rd_ptr [2];
   logic [AW:0]   count  [2];
   logic [4:0]    in_reg [2];
   logic [63:0]   in_data[2];

   logic [1:0]    valid_in, ready, push, pop, head_valid;
   logic          any_grant;
   logic [4:0]    gnt_reg;
   logic [63:0]   gnt_data;

   logic          last_b;
   logic          regwr_q;
   logic [4:0]    rw_q;
   logic [63:0]   busw_q;

   logic          haz_a, haz_b;
   logic [AW-1:0] off;

   always_comb begin
      valid_in   = {bus.ValidB, bus.ValidA};
      in_reg[0]  = bus.RegA;
      in_reg[1]  = bus.RegB;
      in_data[0] = bus.DataA;
      in_data[1] = bus.DataB;
      for (int unsigned q = 0; q < 2; q++) begin
         // Ready depends on stored occupancy only: a same-cycle pop never frees a full FIFO
         ready[q]      = (count[q] != FULL);
         push[q]       = valid_in[q] & ready[q];
         head_valid[q] = (count[q] != '0);
      end
      // Tie goes to the requester not granted last
      pop[1]    = head_valid[1] & (~head_valid[0] | ~last_b);
      pop[0]    = head_valid[0] & (~head_valid[1] | last_b);
      any_grant = |pop;
      gnt_reg   = pop[1] ? q_reg[1][rd_ptr[1]]  : q_reg[0][rd_ptr[0]];
      gnt_data  = pop[1] ? q_data[1][rd_ptr[1]] : q_data[0][rd_ptr[0]];
   end

   // Storage needs no reset: occupancy counters hide stale entries
   always_ff @(posedge Clk) begin
      for (int unsigned q = 0; q < 2; q++) begin
         if (push[q]) begin
            q_reg[q][wr_ptr[q]]  <= in_reg[q];
            q_data[q][wr_ptr[q]] <= in_data[q];
         end
      end
   end

   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         for (int unsigned q = 0; q < 2; q++) begin
            wr_ptr[q] <= '0;
            rd_ptr[q] <= '0;
            count[q]  <= '0;
         end
         last_b  <= 1'b1;
         regwr_q <= 1'b0;
         rw_q    <= '0;
         busw_q  <= '0;
      end else begin
         for (int unsigned q = 0; q < 2; q++) begin
            if (push[q]) wr_ptr[q] <= wr_ptr[q] + 1'b1;
            if (pop[q])  rd_ptr[q] <= rd_ptr[q] + 1'b1;
            case ({push[q], pop[q]})
               2'b10:   count[q] <= count[q] + 1'b1;
               2'b01:   count[q] <= count[q] - 1'b1;
               default: count[q] <= count[q];
            endcase
         end
         if (any_grant) begin
            rw_q    <= gnt_reg;
            busw_q  <= gnt_data;
            last_b  <= pop[1];
            regwr_q <= (gnt_reg != REG_NULL);
         end else begin
            regwr_q <= 1'b0;
         end
      end
   end

   // Hazard scan: entry i is live when its distance from the read pointer is below occupancy
   always_comb begin
      haz_a = 1'b0;
      haz_b = 1'b0;
      off   = '0;
      for (int unsigned q = 0; q < 2; q++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr[q];
            if ({1'b0, off} < count[q]) begin
               if (q_reg[q][i] == bus.RA) haz_a = 1'b1;
               if (q_reg[q][i] == bus.RB) haz_b = 1'b1;
            end
         end
      end
      if (regwr_q && (rw_q == bus.RA)) haz_a = 1'b1;
      if (regwr_q && (rw_q == bus.RB)) haz_b = 1'b1;
      if (bus.RA == REG_NULL) haz_a = 1'b0;
      if (bus.RB == REG_NULL) haz_b = 1'b0;
   end

   assign bus.ReadyA = ready[0];
   assign bus.ReadyB = ready[1];
   assign bus.RW     = rw_q;
   assign bus.BusW   = busw_q;
   assign bus.RegWr  = regwr_q;
   assign bus.HazA   = haz_a;
   assign bus.HazB   = haz_b;
   assign bus.Busy   = (|head_valid) | regwr_q;
endmodule
